// File: rtl/cmp_stream_downsizer_if.sv
// Stream bundle (data/valid/ready/last) of parameterized width.
// The master drives data, valid and last, and the slave drives ready.
interface cmp_stream_downsizer_if #(
  parameter int W = 64
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/cmp_stream_downsizer.sv
// Splits wide compressed words into OUT_WIDTH beats, MSB slice first, and reports the per-packet beat count.
// The first beat appears 1 cycle after a word is accepted. Ready stalls the beat in place, and the next word is taken on the final beat.
module cmp_stream_downsizer #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 64,
  parameter int RATIO     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wrt_en,
  cmp_stream_downsizer_if.slave        s_axis,
  cmp_stream_downsizer_if.master       m_axis,
  output logic [CNT_WIDTH-1:0]         pkt_len,
  output logic                         pkt_len_valid,
  output logic                         pkt_len_ovf
);

  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (IN_WIDTH != RATIO * OUT_WIDTH || RATIO < 2) begin : g_bad_cfg
    $error("cmp_stream_downsizer: IN_WIDTH must equal RATIO*OUT_WIDTH with RATIO >= 2");
  end

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                              state_q;
  logic [RATIO-1:0][OUT_WIDTH-1:0]     hold_q;
  logic                                last_q;
  logic [IDX_W-1:0]                    idx_q;
  logic                                rdy_q;
  logic [CNT_WIDTH-1:0]                cnt_q;
  logic [CNT_WIDTH-1:0]                cnt_d;
  logic                                ovf_q;
  logic [CNT_WIDTH-1:0]                len_q;
  logic                                len_vld_q;
  logic                                len_ovf_q;

  logic at_last_beat;
  logic at_max;
  logic tvalid_out;
  logic tready_out;
  logic tlast_out;
  logic in_fire;
  logic out_fire;

  assign at_last_beat = (idx_q == LAST_IDX);
  assign tvalid_out   = wrt_en & (state_q == SEND);
  assign tlast_out    = (state_q == SEND) & last_q & at_last_beat;
  assign tready_out   = wrt_en & rdy_q &
                        ((state_q == IDLE) | ((state_q == SEND) & at_last_beat & m_axis.tready));
  assign in_fire      = s_axis.tvalid & tready_out;
  assign out_fire     = tvalid_out & m_axis.tready;

  // Slice RATIO-1 of the hold register is the MSB slice, so idx 0 selects it.
  assign m_axis.tdata  = hold_q[LAST_IDX - idx_q];
  assign m_axis.tvalid = tvalid_out;
  assign m_axis.tlast  = tlast_out;
  assign s_axis.tready = tready_out;

  assign pkt_len       = len_q;
  assign pkt_len_valid = len_vld_q;
  assign pkt_len_ovf   = len_ovf_q;

  // A beat that arrives while the counter is already saturated marks the packet as overflowed.
  assign at_max = &cnt_q;
  assign cnt_d  = at_max ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      last_q    <= 1'b0;
      idx_q     <= '0;
      rdy_q     <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      len_q     <= '0;
      len_vld_q <= 1'b0;
      len_ovf_q <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      len_vld_q <= 1'b0;
      len_ovf_q <= 1'b0;

      if (out_fire) begin
        if (tlast_out) begin
          len_q     <= cnt_d;
          len_vld_q <= 1'b1;
          len_ovf_q <= ovf_q | at_max;
          cnt_q     <= '0;
          ovf_q     <= 1'b0;
        end else begin
          cnt_q     <= cnt_d;
          ovf_q     <= ovf_q | at_max;
        end
      end

      case (state_q)
        IDLE: begin
          if (in_fire) begin
            hold_q  <= s_axis.tdata;
            last_q  <= s_axis.tlast;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_fire) begin
            if (!at_last_beat) begin
              idx_q <= idx_q + IDX_W'(1);
            end else if (in_fire) begin
              hold_q <= s_axis.tdata;
              last_q <= s_axis.tlast;
              idx_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
